// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, FSM states, divide sizing.
package mdu_pkg;

    localparam int DIV_STEPS = 32;
    localparam int CNT_BITS  = 5;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'd0,
        MDU_MULTU = 2'd1,
        MDU_DIV   = 2'd2,
        MDU_DIVU  = 2'd3
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } mdu_state_e;

endpackage

// File: rtl/mdu_div_core.sv
// Unsigned restoring radix-2 divider: one quotient bit per step, MSB first.
// A zero divisor naturally yields quotient all-ones and remainder = dividend.
module mdu_div_core #(
    parameter int DATA_BITS = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 step,
    input  logic [DATA_BITS-1:0] dividend,
    input  logic [DATA_BITS-1:0] divisor,
    output logic [DATA_BITS-1:0] quotient,
    output logic [DATA_BITS-1:0] remainder
);

    logic [DATA_BITS-1:0] quo_reg;
    logic [DATA_BITS-1:0] rem_reg;
    logic [DATA_BITS-1:0] dvs_reg;
    logic [DATA_BITS:0]   shifted;
    logic [DATA_BITS:0]   diff;

    // Partial remainder shifted left with the next dividend bit, then trial-subtracted.
    always_comb begin
        shifted = {rem_reg, quo_reg[DATA_BITS-1]};
        diff    = shifted - {1'b0, dvs_reg};
    end

    // Dividend register doubles as the quotient shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quo_reg <= '0;
            rem_reg <= '0;
            dvs_reg <= '0;
        end else if (load) begin
            quo_reg <= dividend;
            rem_reg <= '0;
            dvs_reg <= divisor;
        end else if (step) begin
            if (!diff[DATA_BITS]) begin
                rem_reg <= diff[DATA_BITS-1:0];
                quo_reg <= {quo_reg[DATA_BITS-2:0], 1'b1};
            end else begin
                rem_reg <= shifted[DATA_BITS-1:0];
                quo_reg <= {quo_reg[DATA_BITS-2:0], 1'b0};
            end
        end
    end

    assign quotient  = quo_reg;
    assign remainder = rem_reg;

endmodule

// File: rtl/mult_div_unit.sv
// MIPS HI/LO multiply/divide unit: single-cycle multiply, 32-step divide plus sign fix.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int DATA_BITS = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic [DATA_BITS-1:0] src_a,
    input  logic [DATA_BITS-1:0] src_b,
    input  logic                 mthi,
    input  logic                 mtlo,
    input  logic [DATA_BITS-1:0] wdata,
    input  logic                 cancel,
    output logic                 busy,
    output logic                 done,
    output logic [DATA_BITS-1:0] hi,
    output logic [DATA_BITS-1:0] lo
);

    mdu_state_e             state_reg, state_next;
    logic [CNT_BITS-1:0]    cnt_reg;
    logic [DATA_BITS-1:0]   a_reg, b_reg;
    logic                   signed_reg;
    logic [DATA_BITS-1:0]   hi_reg, lo_reg;
    logic                   done_reg;

    logic                   accept, load, step, wr_mul, wr_div;
    logic                   op_signed;
    logic [DATA_BITS-1:0]   a_mag, b_mag;
    logic [2*DATA_BITS-1:0] ext_a, ext_b, product;
    logic [DATA_BITS-1:0]   core_q, core_r, q_fix, r_fix;

    // Even op codes (MULT, DIV) are the signed variants.
    assign op_signed = ~op[0];
    assign busy      = (state_reg != IDLE);

    // Magnitudes handed to the unsigned divider at issue time.
    always_comb begin
        a_mag = (op_signed && src_a[DATA_BITS-1]) ? (~src_a + 1'b1) : src_a;
        b_mag = (op_signed && src_b[DATA_BITS-1]) ? (~src_b + 1'b1) : src_b;
    end

    // Full-width product from sign- or zero-extended captured operands.
    always_comb begin
        ext_a   = {{DATA_BITS{signed_reg & a_reg[DATA_BITS-1]}}, a_reg};
        ext_b   = {{DATA_BITS{signed_reg & b_reg[DATA_BITS-1]}}, b_reg};
        product = ext_a * ext_b;
    end

    // Sign fix: quotient negated on sign mismatch, remainder follows the dividend.
    always_comb begin
        q_fix = (signed_reg && (a_reg[DATA_BITS-1] ^ b_reg[DATA_BITS-1])) ? (~core_q + 1'b1) : core_q;
        r_fix = (signed_reg && a_reg[DATA_BITS-1]) ? (~core_r + 1'b1) : core_r;
    end

    mdu_div_core #(.DATA_BITS(DATA_BITS)) u_div_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .step      (step),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .quotient  (core_q),
        .remainder (core_r)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // Next-state and datapath strobes; cancel overrides everything while busy.
    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        load       = 1'b0;
        step       = 1'b0;
        wr_mul     = 1'b0;
        wr_div     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start && !cancel) begin
                    accept     = 1'b1;
                    load       = op[1];
                    state_next = op[1] ? DIV : MUL;
                end
            end
            MUL: begin
                state_next = IDLE;
                wr_mul     = ~cancel;
            end
            DIV: begin
                if (cancel) begin
                    state_next = IDLE;
                end else begin
                    step = 1'b1;
                    if (cnt_reg == CNT_BITS'(DIV_STEPS - 1)) state_next = FIX;
                end
            end
            FIX: begin
                state_next = IDLE;
                wr_div     = ~cancel;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture and divide step counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg      <= '0;
            b_reg      <= '0;
            signed_reg <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            if (accept) begin
                a_reg      <= src_a;
                b_reg      <= src_b;
                signed_reg <= op_signed;
            end
            if (load)      cnt_reg <= '0;
            else if (step) cnt_reg <= cnt_reg + 1'b1;
        end
    end

    // HI/LO: MT writes only when idle; op results land at the exit edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_reg   <= '0;
            lo_reg   <= '0;
            done_reg <= 1'b0;
        end else begin
            done_reg <= wr_mul | wr_div;
            if (wr_mul) begin
                hi_reg <= product[2*DATA_BITS-1:DATA_BITS];
                lo_reg <= product[DATA_BITS-1:0];
            end else if (wr_div) begin
                hi_reg <= r_fix;
                lo_reg <= q_fix;
            end else if (!busy) begin
                if (mthi) hi_reg <= wdata;
                if (mtlo) lo_reg <= wdata;
            end
        end
    end

    assign done = done_reg;
    assign hi   = hi_reg;
    assign lo   = lo_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit against an arithmetic reference model.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a, src_b, wdata;
    logic        mthi, mtlo, cancel;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mult_div_unit #(.DATA_BITS(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .src_a  (src_a),
        .src_b  (src_b),
        .mthi   (mthi),
        .mtlo   (mtlo),
        .wdata  (wdata),
        .cancel (cancel),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    // Architectural result {hi,lo} computed with plain integer arithmetic.
    function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb;
        logic [31:0] q;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = '0;
        case (o)
            2'd0: r = 64'(sa * sb);
            2'd1: r = {32'd0, a} * {32'd0, b};
            2'd2: begin
                if (b == 0) begin
                    q = 32'hFFFF_FFFF;
                    if (a[31]) q = -q;
                    r = {a, q};
                end else begin
                    r = {32'(sa % sb), 32'(sa / sb)};
                end
            end
            default: begin
                if (b == 0) r = {a, 32'hFFFF_FFFF};
                else        r = {a % b, a / b};
            end
        endcase
        return r;
    endfunction

    // Issue one op (caller is just after an edge, unit idle) and wait for busy to drop.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int cyc, output logic dn, output logic [31:0] h, output logic [31:0] l);
        op = o; src_a = a; src_b = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (busy === 1'b1 && cyc < 200) begin
            cyc++;
            @(posedge clk); #1;
        end
        dn = done; h = hi; l = lo;
        $display("op=%0d a=%h b=%h busy_cycles=%0d done=%b hi=%h lo=%h", o, a, b, cyc, dn, h, l);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 0; op = 0; src_a = 0; src_b = 0;
        mthi = 0; mtlo = 0; wdata = 0; cancel = 0;
        #12;
        checks++;
        if ({busy, done, hi, lo} !== 66'd0) begin
            failures++;
            $display("FAIL reset_state got busy=%b done=%b hi=%h lo=%h exp all zero", busy, done, hi, lo);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_mult();
        int cyc; logic dn; logic [31:0] h, l;
        run_op(2'd0, 32'hFFFF_FFFE, 32'h3, cyc, dn, h, l);
        checks++;
        if (cyc !== 1 || dn !== 1'b1) begin
            failures++; $display("FAIL mult_latency got cyc=%0d done=%b exp cyc=1 done=1", cyc, dn);
        end
        checks++;
        if ({h, l} !== 64'hFFFF_FFFF_FFFF_FFFA) begin
            failures++; $display("FAIL mult_result got=%h exp=%h", {h, l}, 64'hFFFF_FFFF_FFFF_FFFA);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0) begin
            failures++; $display("FAIL done_one_cycle got=%b exp=0", done);
        end
        run_op(2'd1, 32'hFFFF_FFFE, 32'h3, cyc, dn, h, l);
        checks++;
        if ({h, l} !== 64'h0000_0002_FFFF_FFFA || dn !== 1'b1) begin
            failures++; $display("FAIL multu_result got=%h done=%b exp=%h done=1", {h, l}, dn, 64'h0000_0002_FFFF_FFFA);
        end
    endtask

    task automatic test_div();
        int cyc; logic dn; logic [31:0] h, l;
        run_op(2'd2, 32'hFFFF_FFF9, 32'h2, cyc, dn, h, l);
        checks++;
        if (cyc !== 33 || dn !== 1'b1) begin
            failures++; $display("FAIL div_latency got cyc=%0d done=%b exp cyc=33 done=1", cyc, dn);
        end
        checks++;
        if ({h, l} !== 64'hFFFF_FFFF_FFFF_FFFD) begin
            failures++; $display("FAIL div_signed got=%h exp=%h", {h, l}, 64'hFFFF_FFFF_FFFF_FFFD);
        end
        run_op(2'd3, 32'd100, 32'd7, cyc, dn, h, l);
        checks++;
        if (h !== 32'd2 || l !== 32'd14) begin
            failures++; $display("FAIL divu_result got hi=%h lo=%h exp hi=2 lo=e", h, l);
        end
    endtask

    task automatic test_div_corners();
        int cyc; logic dn; logic [31:0] h, l;
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, cyc, dn, h, l);
        checks++;
        if (h !== 32'd0 || l !== 32'h8000_0000) begin
            failures++; $display("FAIL div_overflow got hi=%h lo=%h exp hi=0 lo=80000000", h, l);
        end
        run_op(2'd3, 32'd5, 32'd0, cyc, dn, h, l);
        checks++;
        if (h !== 32'd5 || l !== 32'hFFFF_FFFF || cyc !== 33) begin
            failures++; $display("FAIL divu_by_zero got hi=%h lo=%h cyc=%0d exp hi=5 lo=ffffffff cyc=33", h, l, cyc);
        end
        run_op(2'd2, 32'hFFFF_FFFB, 32'd0, cyc, dn, h, l);
        checks++;
        if ({h, l} !== ref_result(2'd2, 32'hFFFF_FFFB, 32'd0)) begin
            failures++; $display("FAIL div_by_zero_signed got=%h exp=%h", {h, l}, ref_result(2'd2, 32'hFFFF_FFFB, 32'd0));
        end
    endtask

    task automatic test_cancel();
        bit seen_done;
        mthi = 1'b1; wdata = 32'h1234;
        @(posedge clk); #1;
        mthi = 1'b0; mtlo = 1'b1; wdata = 32'h5678;
        @(posedge clk); #1;
        mtlo = 1'b0;
        op = 2'd3; src_a = 32'd9; src_b = 32'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin
            failures++; $display("FAIL cancel_precond_busy got=%b exp=1", busy);
        end
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL cancel_abort got busy=%b done=%b exp busy=0 done=0", busy, done);
        end
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) seen_done = 1;
        end
        checks++;
        if (seen_done || hi !== 32'h1234 || lo !== 32'h5678) begin
            failures++; $display("FAIL cancel_hilo got hi=%h lo=%h late_activity=%0b exp hi=1234 lo=5678 none", hi, lo, seen_done);
        end
        $display("cancel transaction hi=%h lo=%h", hi, lo);
    endtask

    task automatic test_mt_busy();
        int cyc; logic dn; logic [31:0] h, l;
        op = 2'd3; src_a = 32'd1000; src_b = 32'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; mtlo = 1'b1; wdata = 32'hAAAA;
        cyc = 0;
        while (busy === 1'b1 && cyc < 200) begin
            cyc++; @(posedge clk); #1;
        end
        mtlo = 1'b0;
        checks++;
        if (lo !== 32'd111 || hi !== 32'd1 || done !== 1'b1) begin
            failures++; $display("FAIL mtlo_while_busy got hi=%h lo=%h done=%b exp hi=1 lo=6f done=1", hi, lo, done);
        end
        // MT and start on the same edge: the op result wins later.
        mthi = 1'b1; wdata = 32'hBEEF;
        op = 2'd1; src_a = 32'h1_0000; src_b = 32'h1_0000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; mthi = 1'b0;
        checks++;
        if (hi !== 32'hBEEF) begin
            failures++; $display("FAIL mt_with_start_first got hi=%h exp=beef", hi);
        end
        @(posedge clk); #1;
        checks++;
        if (hi !== 32'd1 || lo !== 32'd0) begin
            failures++; $display("FAIL mt_with_start_result got hi=%h lo=%h exp hi=1 lo=0", hi, lo);
        end
        $display("mt transaction hi=%h lo=%h", hi, lo);
    endtask

    task automatic test_back_to_back();
        int cyc; logic dn; logic [31:0] h, l;
        run_op(2'd0, 32'd6, 32'd7, cyc, dn, h, l);
        run_op(2'd2, 32'd50, 32'hFFFF_FFF9, cyc, dn, h, l);
        checks++;
        if ({h, l} !== ref_result(2'd2, 32'd50, 32'hFFFF_FFF9) || cyc !== 33 || dn !== 1'b1) begin
            failures++; $display("FAIL back_to_back got=%h cyc=%0d exp=%h cyc=33", {h, l}, cyc, ref_result(2'd2, 32'd50, 32'hFFFF_FFF9));
        end
    endtask

    task automatic test_random();
        int cyc; logic dn; logic [31:0] h, l, a, b;
        logic [1:0] o;
        for (int i = 0; i < 30; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 20));
            run_op(o, a, b, cyc, dn, h, l);
            checks++;
            if ({h, l} !== ref_result(o, a, b) || dn !== 1'b1 || cyc !== (o[1] ? 33 : 1)) begin
                failures++;
                $display("FAIL random_op%0d got=%h done=%b cyc=%0d exp=%h", o, {h, l}, dn, cyc, ref_result(o, a, b));
            end
        end
    endtask

    task automatic test_reset_mid();
        int cyc; logic dn; logic [31:0] h, l;
        op = 2'd2; src_a = 32'd12345; src_b = 32'd17; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, hi, lo} !== 66'd0) begin
            failures++; $display("FAIL reset_mid_div got busy=%b done=%b hi=%h lo=%h exp all zero", busy, done, hi, lo);
        end
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL reset_release_idle got busy=%b done=%b exp 0 0", busy, done);
        end
        run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc, dn, h, l);
        checks++;
        if ({h, l} !== 64'd1 || dn !== 1'b1) begin
            failures++; $display("FAIL mult_after_reset got=%h done=%b exp=1 done=1", {h, l}, dn);
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_corners();
        test_cancel();
        test_mt_busy();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multi-cycle MIPS multiply/divide unit that owns the HI/LO special registers.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Drives `lo`/`hi` directly into the writeback data-select stage (LO/HI-to-register path).
- Asserts `busy` so the hazard unit stalls MFHI/MFLO and further mult/div issue; `cancel` aborts on exception/interrupt.

Parameters:
- DATA_BITS, 32, operand and HI/LO width. Only 32 is supported; the divide counter is sized for 32 steps.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  issue pulse for the op on `op`; sampled only while not busy
- op  in  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU
- src_a  in  DATA_BITS  rs operand (dividend / multiplicand)
- src_b  in  DATA_BITS  rt operand (divisor / multiplier)
- mthi  in  1  write `wdata` into HI
- mtlo  in  1  write `wdata` into LO
- wdata  in  DATA_BITS  MTHI/MTLO data
- cancel  in  1  abort the in-flight op; HI/LO retain their pre-op values
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse: new HI/LO visible this cycle
- hi  out  DATA_BITS  HI register
- lo  out  DATA_BITS  LO register

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, busy=0, done=0, hi=0, lo=0.
  - Reset mid-operation discards the operation.
- States:
  - IDLE: busy=0.
    - start with op[1]=0 → MUL.
    - start with op[1]=1 → DIV. Capture |a|, |b| and the sign flags; load step counter=0.
  - MUL: busy=1, one cycle. At the exit edge {hi,lo}={DATA_BITS{..}} 64-bit product (signed for MULT, unsigned for MULTU) → IDLE. done=1 in the following cycle.
  - DIV: busy=1, 32 cycles of restoring radix-2 iteration on unsigned magnitudes. One quotient bit per cycle, MSB first. Counter 0..31; at counter=31 → FIX.
  - FIX: busy=1, one cycle. Apply signs:
    - Quotient is negated if DIV and the operand signs differ.
    - Remainder takes the sign of the dividend (DIV only).
    - At the exit edge lo=quotient, hi=remainder → IDLE; done=1 next cycle.
- Latency from the start-sampling edge:
  - MUL: busy for 1 cycle; done in the 2nd cycle.
  - DIV: busy for 33 cycles; done in the 34th cycle.
- done:
  - Pulse is exactly one cycle long, with busy=0 in that cycle.
  - A new start may be sampled in the done cycle.
- start while busy is ignored; the hazard unit guarantees it is never issued.
- mthi/mtlo:
  - Take effect at the next edge when busy=0.
  - Ignored while busy=1.
  - If sampled together with start at the same edge, the MT write happens first; the op result later overwrites it.
- cancel:
  - When asserted in any busy state: → IDLE at the next edge, HI/LO unchanged, no done pulse.
  - cancel together with start in IDLE: start is not accepted.
  - cancel in IDLE otherwise has no effect.
- Divide by zero (architecturally undefined), fixed deterministically:
  - Full 33 cycles are still taken.
  - Unsigned core result: quotient=0xFFFFFFFF, remainder=|dividend|; sign fix then applies as normal.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0. This falls out of magnitude arithmetic with no special case.
- Width rules:
  - Magnitudes are DATA_BITS unsigned; the partial remainder is DATA_BITS+1 bits.
  - Negation is two's complement modulo 2^DATA_BITS.

Decomposition:
- Package mdu_pkg:
  - op encodings (MDU_MULT=0, MDU_MULTU=1, MDU_DIV=2, MDU_DIVU=3).
  - state enum (IDLE, MUL, DIV, FIX).
  - DIV_STEPS=32 and counter width 5.
- One sub-module: mdu_div_core, the unsigned iterative divider.
  - Inputs: load, step, magnitudes.
  - Outputs: quotient, remainder.
- Sign handling, the multiplier, HI/LO registers and the FSM stay in the top module.

Test Plan:
- MULT 0xFFFFFFFE × 0x00000003 → busy 1 cycle, done in cycle 2, hi=0xFFFFFFFF, lo=0xFFFFFFFA. Same operands with MULTU → hi=0x00000002, lo=0xFFFFFFFA.
- DIV −7 (0xFFFFFFF9) / 2 → busy exactly 33 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 → lo=14, hi=2.
- DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0. DIVU 5/0 → lo=0xFFFFFFFF, hi=5.
- Preload mthi=0x1234, mtlo=0x5678; start DIVU 9/2; cancel at busy cycle 10 → busy drops the next cycle, no done, hi=0x1234, lo=0x5678.
- mtlo=0xAAAA asserted during busy → ignored. Back-to-back start in the done cycle → accepted, second result correct.
- rst_n low at DIV cycle 5 → busy, done, hi, lo all 0 immediately. After release, the FSM is IDLE and a new MULT works.
